// File: rtl/downlink_pkg.sv
// Shared types and timing constants for the Manchester downlink receiver.
// Parity framing is selected by DOWNLINK_RX_PARITY_EN (9-bit characters when defined).
package downlink_pkg;

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

  localparam int HALF_BIT_DEF = 25;
  localparam logic [7:0] SYNC_WORD_DEF = 8'h7E;

  function automatic int edge_min_of(input int half_bit);
    return (3 * 2 * half_bit) / 4;
  endfunction

  function automatic int timeout_of(input int half_bit);
    return (5 * 2 * half_bit) / 4;
  endfunction

  localparam int EDGE_MIN = edge_min_of(HALF_BIT_DEF);
  localparam int TIMEOUT = timeout_of(HALF_BIT_DEF);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

endpackage

// File: rtl/downlink_edge_detect.sv
// Two-flop synchronizer plus a registered copy of the level; rise/fall flag a change.
// Latency: 2 clocks from pin to level/rise/fall; no backpressure.
module downlink_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  assign level = sync2_q;

endmodule

// File: rtl/downlink_manchester_receiver.sv
// Manchester downlink receiver: edge-timed bit recovery, sync hunt, byte delivery (DOWNLINK_RX_PARITY_EN adds parity).
// Latency 3 clocks pin-to-data_valid; a byte completing while the previous one is unaccepted is dropped and flags overrun.
module downlink_manchester_receiver
  import downlink_pkg::*;
#(
  parameter int         HALF_BIT  = HALF_BIT_DEF,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       downlink_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_start,
  output logic       frame_end,
  output logic       overrun,
  output logic       parity_error,
  output logic       busy
);

  localparam int TOUT = timeout_of(HALF_BIT);
  localparam int CW = $clog2(TOUT + 1);
  localparam logic [CW-1:0] EDGE_MIN_C   = CW'(edge_min_of(HALF_BIT));
  localparam logic [CW-1:0] TIMEOUT_C    = CW'(TOUT);
  localparam logic [CW-1:0] TIMEOUT_M1_C = CW'(TOUT - 1);

  logic rise, fall, level;

  downlink_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .din   (downlink_in),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_end_q, frame_end_d;
  logic          overrun_q, overrun_d;
`ifdef DOWNLINK_RX_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  logic       edge_acc, timeout_hit, byte_done;
  logic [7:0] shift_in, new_byte;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    overrun_d     = overrun_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    byte_done     = 1'b0;
    new_byte      = 8'h00;
`ifdef DOWNLINK_RX_PARITY_EN
    par_err_d     = par_err_q;
`endif
    shift_in = {shift_q[6:0], level};
    // Edges inside the window are bit-boundary transitions; an edge wins over a same-cycle timeout.
    edge_acc    = (rise | fall) && ((state_q == IDLE) || (cnt_q >= EDGE_MIN_C));
    timeout_hit = !edge_acc && (cnt_q >= TIMEOUT_M1_C);

    if (edge_acc) cnt_d = '0;
    else if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (edge_acc) begin
          shift_d = shift_in;
          state_d = HUNT;
        end
      end
      HUNT: begin
        if (edge_acc) begin
          shift_d = shift_in;
          if (shift_in == SYNC_WORD) begin
            frame_start_d = 1'b1;
            state_d       = DATA;
            overrun_d     = 1'b0;
            bitcnt_d      = '0;
`ifdef DOWNLINK_RX_PARITY_EN
            par_err_d     = 1'b0;
`endif
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          shift_d = '0;
        end
      end
      DATA: begin
        if (edge_acc) begin
`ifdef DOWNLINK_RX_PARITY_EN
          if (bitcnt_q == 4'd8) begin
            bitcnt_d  = '0;
            byte_done = 1'b1;
            new_byte  = shift_q;
            if ((^shift_q) != level) par_err_d = 1'b1;
          end else begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 4'd1;
          end
`else
          shift_d = shift_in;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d  = '0;
            byte_done = 1'b1;
            new_byte  = shift_in;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
`endif
        end else if (timeout_hit) begin
          frame_end_d = 1'b1;
          state_d     = IDLE;
          shift_d     = '0;
          bitcnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (data_valid_q && data_ready) data_valid_d = 1'b0;
    if (byte_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = new_byte;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      bitcnt_q      <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef DOWNLINK_RX_PARITY_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      bitcnt_q      <= bitcnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      overrun_q     <= overrun_d;
`ifdef DOWNLINK_RX_PARITY_EN
      par_err_q     <= par_err_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);
`ifdef DOWNLINK_RX_PARITY_EN
  assign parity_error = par_err_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_downlink_manchester_receiver.sv
// Randomized frame bench with a byte scoreboard drained by an independent monitor.
// Expected bytes come from the payload list the driver encodes, not from the DUT.
module tb_downlink_manchester_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       downlink_in = 1'b0;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_start, frame_end, overrun, parity_error, busy;

`ifdef DOWNLINK_RX_PARITY_EN
  localparam int CB = 9;
`else
  localparam int CB = 8;
`endif
  // Pin change to frame_end: two synchronizer flops, the edge register, then the 62-clock timeout.
  localparam int FE_DELAY = 65;

  int total = 0, bad = 0;
  int cyc = 0, last_mid = 0;
  int fs_cnt = 0, fe_cnt = 0, fe_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] pl[$];

  downlink_manchester_receiver dut (
    .clock        (clock),
    .reset        (reset),
    .downlink_in  (downlink_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .overrun      (overrun),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got 0x%0h want none", data_out);
        end else begin
          exp_b = exp_q.pop_front();
          chk("byte", int'(data_out), int'(exp_b));
        end
      end
      if (frame_start) fs_cnt++;
      if (frame_end) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
    end
  end

  task automatic send_bit(input bit b, input bit jit, input bit glitch);
    int h1, h2;
    h1 = jit ? (($urandom_range(0, 1) == 1) ? 28 : 22) : 25;
    h2 = jit ? (($urandom_range(0, 1) == 1) ? 28 : 22) : 25;
    downlink_in = ~b;
    repeat (h1) @(negedge clock);
    downlink_in = b;
    last_mid = cyc;
    if (glitch) begin
      repeat (12) @(negedge clock);
      downlink_in = ~b;
      repeat (2) @(negedge clock);
      downlink_in = b;
      repeat (h2 - 14) @(negedge clock);
    end else begin
      repeat (h2) @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] p[$], input bit jit, input bit glitch,
                            input bit bad_par, input int stop_bits, input bit do_rst);
    bit bits[$];
    logic [7:0] sw;
    int n;
    sw = 8'h7E;
    for (int i = 0; i < 16; i++) send_bit((i % 2) == 0, jit, glitch);
    for (int i = 7; i >= 0; i--) send_bit(sw[i], jit, glitch);
    foreach (p[k]) begin
      for (int i = 7; i >= 0; i--) bits.push_back(p[k][i]);
`ifdef DOWNLINK_RX_PARITY_EN
      bits.push_back((^p[k]) ^ bad_par);
`endif
    end
    n = (stop_bits < 0) ? bits.size() : stop_bits;
    for (int i = 0; i < n; i++) send_bit(bits[i], jit, glitch);
    if (do_rst) begin
      chk("rst_busy_before", int'(busy), 1);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_mid_outputs", int'({data_out, data_valid, frame_start, frame_end, overrun, parity_error, busy}), 0);
      reset = 1'b1;
    end
    downlink_in = 1'b0;
  endtask

  task automatic wait_fe(input string name, input int fe0);
    int t;
    t = 0;
    while (fe_cnt == fe0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    chk({name, "_frame_end"}, fe_cnt - fe0, 1);
    if (fe_cnt != fe0) chk({name, "_fe_delay"}, fe_cyc - last_mid, FE_DELAY);
  endtask

  task automatic run_frame(input string name, input logic [7:0] p[$], input bit jit, input bit glitch,
                           input bit bad_par, input int stop_bits, input int n_exp);
    int fs0, fe0;
    for (int k = 0; k < n_exp; k++) exp_q.push_back(p[k]);
    fs0 = fs_cnt;
    fe0 = fe_cnt;
    send_frame(p, jit, glitch, bad_par, stop_bits, 1'b0);
    wait_fe(name, fe0);
    chk({name, "_frame_start"}, fs_cnt - fs0, 1);
    repeat (5) @(negedge clock);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int fs0, fe0, n;
    repeat (3) @(negedge clock);
    chk("reset_outputs", int'({data_out, data_valid, frame_start, frame_end, overrun, parity_error, busy}), 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    pl = '{8'h3C, 8'hA5};
    run_frame("exact", pl, 1'b0, 1'b0, 1'b0, -1, 2);
    chk("exact_overrun", int'(overrun), 0);

    data_ready = 1'b0;
    fs0 = fs_cnt;
    fe0 = fe_cnt;
    send_frame(pl, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    wait_fe("stall", fe0);
    chk("stall_frame_start", fs_cnt - fs0, 1);
    chk("stall_valid", int'(data_valid), 1);
    chk("stall_data", int'(data_out), 8'h3C);
    chk("stall_overrun", int'(overrun), 1);
    exp_q.push_back(8'h3C);
    @(posedge clock);
    #2 data_ready = 1'b1;
    @(posedge clock);
    #2;
    chk("stall_drain_valid", int'(data_valid), 0);
    chk("stall_drain_pending", exp_q.size(), 0);
    @(negedge clock);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(2, 4);
      pl.delete();
      for (int k = 0; k < n; k++) pl.push_back(8'($urandom_range(0, 255)));
      run_frame("jitter", pl, 1'b1, 1'b1, 1'b0, -1, n);
      chk("jitter_overrun", int'(overrun), 0);
    end

    pl = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_frame("abort", pl, 1'b0, 1'b0, 1'b0, CB + 4, 1);

    pl = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    exp_q.push_back(pl[0]);
    fs0 = fs_cnt;
    fe0 = fe_cnt;
    send_frame(pl, 1'b0, 1'b0, 1'b0, CB + 4, 1'b1);
    repeat (300) @(negedge clock);
    chk("rst_no_frame_end", fe_cnt - fe0, 0);
    chk("rst_frame_start", fs_cnt - fs0, 1);
    chk("rst_busy_after", int'(busy), 0);
    chk("rst_pending", exp_q.size(), 0);

    pl = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_frame("after_rst", pl, 1'b1, 1'b0, 1'b0, -1, 3);
    chk("after_rst_overrun", int'(overrun), 0);

`ifdef DOWNLINK_RX_PARITY_EN
    pl = '{8'h03};
    run_frame("par_bad", pl, 1'b0, 1'b0, 1'b1, -1, 1);
    chk("par_bad_flag", int'(parity_error), 1);
    run_frame("par_good", pl, 1'b0, 1'b0, 1'b0, -1, 1);
    chk("par_good_flag", int'(parity_error), 0);
`else
    chk("parity_tied", int'(parity_error), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
